// File: rtl/bus_cycle.sv
// Bus master for one read/write cycle: arbiter request, command phase, response latch, release.
// Latency: IDLE->REQ 1 clk, grant->CMD 1 clk, response or TIMEOUT->REL->FIN, done 1-clk pulse.
// Backpressure: requester holds dr/dw until done and drop; BUS_PARITY_EN enables bus_pe handling.
module bus_cycle #(
  parameter int TIMEOUT = 200
) (
  input  logic        clk_sys,
  input  logic        clo,
  input  logic        dr,
  input  logic        dw,
  input  logic [15:0] dad,
  input  logic [15:0] ddt,
  input  logic [3:0]  dnb,
  output logic        bus_rq,
  input  logic        bus_gnt,
  output logic        bus_r,
  output logic        bus_w,
  output logic [15:0] bus_a,
  output logic [3:0]  bus_nb,
  output logic [15:0] bus_do,
  input  logic [15:0] bus_di,
  input  logic        bus_ok,
  input  logic        bus_en,
  input  logic        bus_pe,
  output logic        rok,
  output logic        ren,
  output logic        rpe,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, REQ, CMD, REL, FIN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [15:0]   adr_q, dat_q;
  logic [3:0]    nb_q;
  logic          wr_q;
  logic          pe_lvl;
  logic          timeout;

`ifdef BUS_PARITY_EN
  assign pe_lvl = bus_pe;
`else
  logic unused_pe;
  assign unused_pe = bus_pe;
  assign pe_lvl    = 1'b0;
`endif

  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or posedge clo) begin
    if (clo) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == CMD && state_nxt == CMD) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_rq    = 1'b0;
    bus_r     = 1'b0;
    bus_w     = 1'b0;
    bus_a     = '0;
    bus_nb    = '0;
    bus_do    = '0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (dr && dw)      state_nxt = FIN;
        else if (dr || dw) state_nxt = REQ;
      end
      REQ: begin
        bus_rq = 1'b1;
        busy   = 1'b1;
        if (bus_gnt) state_nxt = CMD;
      end
      CMD: begin
        // grant is deliberately not looked at once the command phase has begun
        bus_rq = 1'b1;
        busy   = 1'b1;
        bus_r  = ~wr_q;
        bus_w  = wr_q;
        bus_a  = adr_q;
        bus_nb = nb_q;
        bus_do = dat_q;
        if (bus_en || bus_ok || timeout) state_nxt = REL;
      end
      REL: begin
        busy = 1'b1;
        if (!bus_ok && !bus_en && !pe_lvl) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!dr && !dw) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge clo) begin
    if (clo) begin
      adr_q   <= '0;
      dat_q   <= '0;
      nb_q    <= '0;
      wr_q    <= 1'b0;
      rok     <= 1'b0;
      ren     <= 1'b0;
      rpe     <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dr && dw) begin
            rok <= 1'b0;
            ren <= 1'b1;
            rpe <= 1'b0;
          end else if (dr || dw) begin
            rok   <= 1'b0;
            ren   <= 1'b0;
            rpe   <= 1'b0;
            adr_q <= dad;
            dat_q <= ddt;
            nb_q  <= dnb;
            wr_q  <= dw;
          end
        end
        CMD: begin
          // not-present outranks ok; parity only qualifies a successful read
          if (bus_en) begin
            ren <= 1'b1;
          end else if (bus_ok) begin
            rok <= 1'b1;
            if (!wr_q) begin
              rd_data <= bus_di;
              if (pe_lvl) rpe <= 1'b1;
            end
          end else if (timeout) begin
            ren <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle.sv
// Randomized bench for bus_cycle: transaction-level expectations from the cycle rules, per-cycle bus monitor.
`timescale 1ns/1ps
module tb_bus_cycle;

  localparam int TIMEOUT = 200;
  localparam int K_OK = 0, K_EN = 1, K_PE = 2, K_NONE = 3;
`ifdef BUS_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        clo, dr, dw, bus_gnt, bus_ok, bus_en, bus_pe;
  logic [15:0] dad, ddt, bus_di;
  logic [3:0]  dnb;
  logic        bus_rq, bus_r, bus_w, rok, ren, rpe, done, busy;
  logic [15:0] bus_a, bus_do, rd_data;
  logic [3:0]  bus_nb;

  always #5 clk_sys = ~clk_sys;

  bus_cycle #(.TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .clo(clo), .dr(dr), .dw(dw), .dad(dad), .ddt(ddt), .dnb(dnb),
    .bus_rq(bus_rq), .bus_gnt(bus_gnt), .bus_r(bus_r), .bus_w(bus_w), .bus_a(bus_a),
    .bus_nb(bus_nb), .bus_do(bus_do), .bus_di(bus_di), .bus_ok(bus_ok), .bus_en(bus_en),
    .bus_pe(bus_pe), .rok(rok), .ren(ren), .rpe(rpe), .rd_data(rd_data), .done(done), .busy(busy)
  );

  wire [59:0] outs = {bus_rq, bus_r, bus_w, bus_a, bus_nb, bus_do, rok, ren, rpe, rd_data, done, busy};

  int n_checks = 0, n_errors = 0;
  int m_rq, m_r, m_w, m_done, m_busy, m_bad;
  bit          mon_wr;
  logic [15:0] mon_a, mon_d;
  logic [3:0]  mon_nb;
  logic [15:0] mdl_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    m_rq = 0; m_r = 0; m_w = 0; m_done = 0; m_busy = 0; m_bad = 0;
  endtask

  // per-cycle bus observation: command-phase contents and idle-bus quietness
  always @(negedge clk_sys) begin
    m_rq   += int'(bus_rq);
    m_r    += int'(bus_r);
    m_w    += int'(bus_w);
    m_done += int'(done);
    m_busy += int'(busy);
    if (bus_r || bus_w) begin
      if (bus_r == mon_wr || bus_w != mon_wr || bus_a != mon_a || bus_nb != mon_nb || bus_do != mon_d)
        m_bad++;
    end else if (bus_a != 0 || bus_nb != 0 || bus_do != 0) begin
      m_bad++;
    end
    if (rok && ren) m_bad++;
  end

  task automatic run_txn(input string nm, input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input logic [3:0] nb, input int gnt_dly, input int kind, input int resp_dly,
                         input int rel_hold, input int hold, input bit drop_gnt, input logic [15:0] di);
    int cmd_len, rel_len, t;
    bit e_rok, e_ren, e_rpe;
    @(negedge clk_sys);
    mon_clear();
    mon_wr = wr; mon_a = a; mon_d = d; mon_nb = nb;
    dad = a; ddt = d; dnb = nb; dr = ~wr; dw = wr;
    @(negedge clk_sys);
    dad = 16'($urandom); ddt = 16'($urandom); dnb = 4'($urandom);
    repeat (gnt_dly) @(negedge clk_sys);
    bus_gnt = 1'b1;
    @(negedge clk_sys);
    if (drop_gnt) bus_gnt = 1'b0;
    if (kind != K_NONE) begin
      repeat (resp_dly) @(negedge clk_sys);
      bus_di = di;
      case (kind)
        K_OK: bus_ok = 1'b1;
        K_EN: begin bus_en = 1'b1; bus_ok = 1'($urandom); bus_pe = 1'($urandom); end
        default: begin bus_ok = 1'b1; bus_pe = 1'b1; end
      endcase
      repeat (rel_hold + 1) @(negedge clk_sys);
      bus_ok = 1'b0; bus_en = 1'b0; bus_pe = 1'b0;
      bus_di = 16'($urandom);
    end
    t = 0;
    while (!done && t < TIMEOUT + 20) begin
      @(negedge clk_sys);
      t++;
    end
    check({nm, ".done_seen"}, done, 1);
    bus_gnt = 1'b0;
    repeat (hold) @(negedge clk_sys);
    dr = 1'b0; dw = 1'b0;
    repeat (3) @(negedge clk_sys);

    cmd_len = (kind == K_NONE) ? TIMEOUT : resp_dly + 1;
    rel_len = (kind == K_NONE) ? 1 : rel_hold + 1;
    e_rok = (kind == K_OK || kind == K_PE);
    e_ren = (kind == K_EN || kind == K_NONE);
    e_rpe = PAR && kind == K_PE && !wr;
    if (!wr && e_rok) mdl_rd = di;
    check({nm, ".rok"}, rok, e_rok);
    check({nm, ".ren"}, ren, e_ren);
    check({nm, ".rpe"}, rpe, e_rpe);
    check({nm, ".rd_data"}, rd_data, mdl_rd);
    check({nm, ".bus_r_cycles"}, m_r, wr ? 0 : cmd_len);
    check({nm, ".bus_w_cycles"}, m_w, wr ? cmd_len : 0);
    check({nm, ".bus_rq_cycles"}, m_rq, gnt_dly + 1 + cmd_len);
    check({nm, ".done_pulses"}, m_done, 1);
    check({nm, ".busy_cycles"}, m_busy, gnt_dly + 1 + cmd_len + rel_len + 1);
    check({nm, ".bus_content"}, m_bad, 0);
  endtask

  task automatic run_both();
    @(negedge clk_sys);
    mon_clear();
    dr = 1'b1; dw = 1'b1;
    @(negedge clk_sys);
    check("both.done_next", done, 1);
    repeat (5) @(negedge clk_sys);
    dr = 1'b0; dw = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("both.ren", ren, 1);
    check("both.rok", rok, 0);
    check("both.rpe", rpe, 0);
    check("both.rd_data", rd_data, mdl_rd);
    check("both.bus_rq_cycles", m_rq, 0);
    check("both.done_pulses", m_done, 1);
    check("both.busy_cycles", m_busy, 1);
  endtask

  task automatic run_reset();
    @(negedge clk_sys);
    mon_clear();
    mon_wr = 1'b0; mon_a = 16'h0A0A; mon_d = 16'h5555; mon_nb = 4'h7;
    dad = mon_a; ddt = mon_d; dnb = mon_nb; dr = 1'b1;
    @(negedge clk_sys);
    bus_gnt = 1'b1;
    @(negedge clk_sys);
    check("rst.in_cmd", bus_r, 1);
    @(negedge clk_sys);
    clo = 1'b1;
    #1;
    check("rst.outputs", outs, 0);
    mdl_rd = 16'h0;
    @(negedge clk_sys);
    clo = 1'b0; dr = 1'b0; bus_gnt = 1'b0;
    mon_clear();
    repeat (4) @(negedge clk_sys);
    check("rst.no_done", m_done, 0);
    check("rst.idle_outputs", outs, 0);
  endtask

  initial begin
    clo = 1'b1; dr = 1'b0; dw = 1'b0; bus_gnt = 1'b0;
    bus_ok = 1'b0; bus_en = 1'b0; bus_pe = 1'b0;
    dad = '0; ddt = '0; dnb = '0; bus_di = '0;
    mon_wr = 1'b0; mon_a = '0; mon_d = '0; mon_nb = '0;
    mdl_rd = 16'h0;
    mon_clear();
    #1;
    check("reset.outputs", outs, 0);
    repeat (2) @(negedge clk_sys);
    clo = 1'b0;

    run_txn("rd_ok",   1'b0, 16'h1234, 16'h0000, 4'h3, 2, K_OK,   3, 0, 0,  1'b0, 16'hBEEF);
    run_txn("wr_en",   1'b1, 16'h4321, 16'h00FF, 4'h9, 1, K_EN,   2, 1, 2,  1'b0, 16'hDEAD);
    run_txn("rd_tmo",  1'b0, 16'h7777, 16'h0000, 4'h1, 0, K_NONE, 0, 0, 10, 1'b0, 16'h0000);
    run_txn("rd_pe",   1'b0, 16'h00A5, 16'h0000, 4'hF, 0, K_PE,   0, 2, 1,  1'b1, 16'hC0DE);
    run_txn("wr_pe",   1'b1, 16'h5A5A, 16'h1357, 4'h2, 3, K_PE,   1, 0, 0,  1'b0, 16'hFACE);
    run_both();
    run_reset();
    run_txn("post_rst", 1'b0, 16'h2468, 16'h0000, 4'h4, 1, K_OK,  1, 0, 0,  1'b0, 16'h9876);

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("rnd%0d", i), 1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
